axil_cmd_master: RTL and testbench
==================================

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles a transaction may take from command acceptance before it is aborted (used only with AXIL_MASTER_TIMEOUT_EN).
REQ-002 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1 (1=write, 0=read), cmd_addr in `AXI_ADDR_WIDTH, cmd_wdata in `AXI_DATA_WIDTH, cmd_wstrb in `AXI_STROBE_WIDTH: the command channel.
REQ-005 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out `AXI_DATA_WIDTH, rsp_resp out `AXI_RESP_WIDTH, rsp_timeout out 1: the response channel.
REQ-006 SHALL have AXI4-Lite master ports M_AXI_AWVALID/AWREADY/AWADDR/AWPROT, WVALID/WREADY/WDATA/WSTRB, BVALID/BREADY/BRESP, ARVALID/ARREADY/ARADDR/ARPROT, RVALID/RREADY/RDATA/RRESP, with widths from axi_configuration.vh and directions mirroring an AXI slave.

Function
REQ-007 SHALL implement states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP, DRAIN; one transaction outstanding at a time.
REQ-008 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid && cmd_ready, latching addr/wdata/wstrb/write.
REQ-009 IDLE -> RD_ADDR (read) or WR_REQ (write) on acceptance; the cycle after acceptance ARVALID, or AWVALID and WVALID together, SHALL be 1.
REQ-010 RD_ADDR: ARVALID held with stable ARADDR until ARREADY; then RD_DATA with RREADY=1; on RVALID latch RDATA/RRESP, go to RESP.
REQ-011 WR_REQ: AWVALID and WVALID each deassert independently after their own handshake; the order of AWREADY vs WREADY (either first, or same cycle) SHALL NOT matter; when both done -> WR_RESP.
REQ-012 WR_RESP: BREADY=1; on BVALID latch BRESP, rsp_rdata=0, go to RESP.
REQ-013 No VALID SHALL ever be withdrawn before its handshake; address/data SHALL be stable while VALID.
REQ-014 RESP: rsp_valid=1 with stable rsp_* until rsp_ready; then IDLE. Minimum command-to-rsp_valid latency with zero-wait slave: 3 cycles (read), 3 cycles (write).
REQ-015 AWPROT and ARPROT SHALL be constant 3'b000; RREADY/BREADY SHALL be 0 outside RD_DATA/WR_RESP/DRAIN.
REQ-016 rsp_resp SHALL pass slave RRESP/BRESP unmodified (OKAY, SLVERR, ...); rsp_timeout=0 for a completed transaction.

Reset
REQ-017 While RSTn=0: state=IDLE, all M_AXI_*VALID=0, RREADY=BREADY=0, rsp_valid=0, rsp_timeout=0, rsp_rdata=0, rsp_resp=0, latched command=0; cmd_ready=1 after release.
REQ-018 Reset asserted mid-transaction SHALL abort immediately to IDLE with no response; the slave is assumed reset by the same RSTn.

Configuration
REQ-019 Macro AXIL_MASTER_TIMEOUT_EN SHALL compile in a watchdog counter cleared on command acceptance and incremented every cycle outside IDLE/RESP/DRAIN.
REQ-020 With AXIL_MASTER_TIMEOUT_EN: counter reaching TIMEOUT_CYCLES SHALL go to RESP with rsp_timeout=1, rsp_resp=`AXI_RESP_SLVERR, rsp_rdata=0; after rsp handshake go to DRAIN (not IDLE).
REQ-021 DRAIN SHALL keep pending VALIDs asserted until handshaked, hold RREADY/BREADY=1, discard the late response, then go to IDLE; cmd_ready=0 throughout.
REQ-022 Without AXIL_MASTER_TIMEOUT_EN: no counter, no DRAIN, rsp_timeout tied 0, transactions wait indefinitely.

Verification
REQ-023 Write addr 0x0000_0101 data 0x1 strb 0xF, slave AWREADY then WREADY one cycle later, BRESP OKAY -> one AW, one W handshake, rsp_resp=OKAY, rsp_rdata=0.
REQ-024 Read addr 0x0000_0205, ARREADY after 3 cycles, RDATA 0xDEAD_BEEF -> ARVALID held 4 cycles, rsp_rdata=0xDEAD_BEEF, rsp_resp=OKAY.
REQ-025 Write with WREADY before AWREADY, slave BRESP SLVERR -> rsp_resp=SLVERR, rsp_timeout=0, no duplicate W.
REQ-026 rsp_ready held 0 for 5 cycles -> rsp_* stable, cmd_ready=0, next command accepted only after handshake.
REQ-027 With AXIL_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, ARREADY never asserted -> rsp_timeout=1, rsp_resp=SLVERR 16 cycles after acceptance; ARVALID still 1 in DRAIN; raising ARREADY then RVALID returns to IDLE.
REQ-028 RSTn pulsed low during RD_DATA -> all VALID/READY 0 asynchronously, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/axil_cmd_master.sv
// Command/response front end driving an AXI4-Lite master port, one transaction outstanding; AXIL_MASTER_TIMEOUT_EN adds a watchdog with DRAIN recovery.
// Latency: rsp_valid 3 cycles after command acceptance with a zero-wait slave (read or write).
// Backpressure: cmd_ready only in IDLE; rsp_* held until rsp_ready; every AXI VALID held until its own handshake.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_STROBE_WIDTH
`define AXI_STROBE_WIDTH 4
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif
`ifndef AXI_RESP_SLVERR
`define AXI_RESP_SLVERR 2'b10
`endif

module axil_cmd_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          CLK,
    input  logic                          RSTn,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [`AXI_ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [`AXI_DATA_WIDTH-1:0]    cmd_wdata,
    input  logic [`AXI_STROBE_WIDTH-1:0]  cmd_wstrb,

    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [`AXI_DATA_WIDTH-1:0]    rsp_rdata,
    output logic [`AXI_RESP_WIDTH-1:0]    rsp_resp,
    output logic                          rsp_timeout,

    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [`AXI_ADDR_WIDTH-1:0]    M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    output logic [`AXI_DATA_WIDTH-1:0]    M_AXI_WDATA,
    output logic [`AXI_STROBE_WIDTH-1:0]  M_AXI_WSTRB,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    input  logic [`AXI_RESP_WIDTH-1:0]    M_AXI_BRESP,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    output logic [`AXI_ADDR_WIDTH-1:0]    M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    input  logic [`AXI_DATA_WIDTH-1:0]    M_AXI_RDATA,
    input  logic [`AXI_RESP_WIDTH-1:0]    M_AXI_RRESP
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axil_cmd_master: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5,
        DRAIN   = 3'd6
    } state_t;

    state_t                          state_q, state_d;
    logic                            wr_q, wr_d;
    logic [`AXI_ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [`AXI_DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [`AXI_STROBE_WIDTH-1:0]    wstrb_q, wstrb_d;
    logic                            aw_vld_q, aw_vld_d;
    logic                            w_vld_q, w_vld_d;
    logic                            ar_vld_q, ar_vld_d;
    logic [`AXI_DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic [`AXI_RESP_WIDTH-1:0]      resp_q, resp_d;
    logic                            active;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]                   timer_q, timer_d;
    logic                            tmo_q, tmo_d;
`endif

    assign active = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                    (state_q == WR_REQ)  || (state_q == WR_RESP);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            aw_vld_q <= 1'b0;
            w_vld_q  <= 1'b0;
            ar_vld_q <= 1'b0;
            rdata_q  <= '0;
            resp_q   <= '0;
`ifdef AXIL_MASTER_TIMEOUT_EN
            timer_q  <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            aw_vld_q <= aw_vld_d;
            w_vld_q  <= w_vld_d;
            ar_vld_q <= ar_vld_d;
            rdata_q  <= rdata_d;
            resp_q   <= resp_d;
`ifdef AXIL_MASTER_TIMEOUT_EN
            timer_q  <= timer_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        // A VALID drops only on its own handshake, whatever state we are in.
        aw_vld_d = aw_vld_q & ~M_AXI_AWREADY;
        w_vld_d  = w_vld_q  & ~M_AXI_WREADY;
        ar_vld_d = ar_vld_q & ~M_AXI_ARREADY;
        rdata_d  = rdata_q;
        resp_d   = resp_q;
`ifdef AXIL_MASTER_TIMEOUT_EN
        timer_d  = timer_q;
        tmo_d    = tmo_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    wr_d    = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
`ifdef AXIL_MASTER_TIMEOUT_EN
                    // The accepting cycle counts as the first cycle of the transaction.
                    timer_d = TW'(1);
`endif
                    if (cmd_write) begin
                        aw_vld_d = 1'b1;
                        w_vld_d  = 1'b1;
                        state_d  = WR_REQ;
                    end else begin
                        ar_vld_d = 1'b1;
                        state_d  = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    state_d = RD_DATA;
                end
            end
            WR_REQ: begin
                if (!aw_vld_d && !w_vld_d) begin
                    state_d = WR_RESP;
                end
            end
            RD_DATA, WR_RESP: begin
                if (wr_q ? M_AXI_BVALID : M_AXI_RVALID) begin
                    rdata_d = wr_q ? '0 : M_AXI_RDATA;
                    resp_d  = wr_q ? M_AXI_BRESP : M_AXI_RRESP;
`ifdef AXIL_MASTER_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
`ifdef AXIL_MASTER_TIMEOUT_EN
                    state_d = tmo_q ? DRAIN : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef AXIL_MASTER_TIMEOUT_EN
            DRAIN: begin
                // The late response can only arrive after all address/data handshakes.
                if (wr_q ? M_AXI_BVALID : M_AXI_RVALID) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
        if (active) begin
            if (int'(timer_q) < TIMEOUT_CYCLES) begin
                timer_d = timer_q + TW'(1);
            end
            // Real progress in the same cycle wins over the watchdog.
            if ((state_d == state_q) && (int'(timer_q) >= TIMEOUT_CYCLES - 1)) begin
                state_d = RESP;
                tmo_d   = 1'b1;
                resp_d  = `AXI_RESP_SLVERR;
                rdata_d = '0;
            end
        end
`endif
    end

    assign cmd_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == RESP);
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
`ifdef AXIL_MASTER_TIMEOUT_EN
    assign rsp_timeout   = tmo_q;
`else
    assign rsp_timeout   = 1'b0;
`endif

    assign M_AXI_AWVALID = aw_vld_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_WVALID  = w_vld_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP) || (state_q == DRAIN);
    assign M_AXI_ARVALID = ar_vld_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = (state_q == RD_DATA) || (state_q == DRAIN);

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed and randomized bench for axil_cmd_master with a cycle-level AXI4-Lite slave and expected-response model.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_STROBE_WIDTH
`define AXI_STROBE_WIDTH 4
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module tb_axil_cmd_master;
    localparam int TO = 16;

    logic                          CLK = 1'b0;
    logic                          RSTn;
    logic                          cmd_valid, cmd_ready, cmd_write;
    logic [`AXI_ADDR_WIDTH-1:0]    cmd_addr;
    logic [`AXI_DATA_WIDTH-1:0]    cmd_wdata;
    logic [`AXI_STROBE_WIDTH-1:0]  cmd_wstrb;
    logic                          rsp_valid, rsp_ready, rsp_timeout;
    logic [`AXI_DATA_WIDTH-1:0]    rsp_rdata;
    logic [`AXI_RESP_WIDTH-1:0]    rsp_resp;
    logic                          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [`AXI_ADDR_WIDTH-1:0]    M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]                    M_AXI_AWPROT, M_AXI_ARPROT;
    logic [`AXI_DATA_WIDTH-1:0]    M_AXI_WDATA, M_AXI_RDATA;
    logic [`AXI_STROBE_WIDTH-1:0]  M_AXI_WSTRB;
    logic                          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic                          M_AXI_RVALID, M_AXI_RREADY;
    logic [`AXI_RESP_WIDTH-1:0]    M_AXI_BRESP, M_AXI_RRESP;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    axil_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_RVALID  = 1'b0;
    endtask

    // One command through a slave that waits the given number of VALID cycles
    // before each READY and the given cycles before the response VALID.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int ar_dly, input int rsp_dly, input logic [31:0] rdata,
                           input logic [1:0] resp, input int hold);
        int cyc = 0;
        int lat = -1;
        int aw_seen = 0, w_seen = 0, ar_seen = 0;
        int aw_hs = 0, w_hs = 0, ar_hs = 0, resp_wait = 0;
        bit resp_done = 1'b0;
        int exp_lat;
        logic [31:0] exp_rdata;
        exp_rdata = wr ? 32'h0 : rdata;
        exp_lat   = wr ? (((aw_dly > w_dly) ? aw_dly : w_dly) + rsp_dly + 3) : (ar_dly + rsp_dly + 3);

        @(negedge CLK);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = strb;
        while (lat < 0 && cyc < 300) begin
            @(negedge CLK);
            cyc++;
            cmd_valid = 1'b0;
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
            slave_idle();
            if (rsp_valid) begin
                lat = cyc;
            end else begin
                check("busy_cmd_ready", cmd_ready, 0);
                if (wr) begin
                    if (aw_hs == 1 && w_hs == 1 && !resp_done) begin
                        resp_wait++;
                        M_AXI_BVALID = (resp_wait > rsp_dly);
                        M_AXI_BRESP  = resp;
                        if (M_AXI_BVALID && M_AXI_BREADY) resp_done = 1'b1;
                    end
                    if (M_AXI_AWVALID) begin
                        check("awaddr", M_AXI_AWADDR, addr);
                        check("awprot", M_AXI_AWPROT, 0);
                        aw_seen++;
                        M_AXI_AWREADY = (aw_seen > aw_dly);
                        if (M_AXI_AWREADY) aw_hs++;
                    end
                    if (M_AXI_WVALID) begin
                        check("wdata", M_AXI_WDATA, wdata);
                        check("wstrb", M_AXI_WSTRB, strb);
                        w_seen++;
                        M_AXI_WREADY = (w_seen > w_dly);
                        if (M_AXI_WREADY) w_hs++;
                    end
                    check("rready_in_write", M_AXI_RREADY, 0);
                    check("arvalid_in_write", M_AXI_ARVALID, 0);
                end else begin
                    if (ar_hs == 1 && !resp_done) begin
                        resp_wait++;
                        M_AXI_RVALID = (resp_wait > rsp_dly);
                        M_AXI_RDATA  = rdata;
                        M_AXI_RRESP  = resp;
                        if (M_AXI_RVALID && M_AXI_RREADY) resp_done = 1'b1;
                    end
                    if (M_AXI_ARVALID) begin
                        check("araddr", M_AXI_ARADDR, addr);
                        check("arprot", M_AXI_ARPROT, 0);
                        ar_seen++;
                        M_AXI_ARREADY = (ar_seen > ar_dly);
                        if (M_AXI_ARREADY) ar_hs++;
                    end
                    check("bready_in_read", M_AXI_BREADY, 0);
                    check("awvalid_in_read", M_AXI_AWVALID, 0);
                    check("wvalid_in_read", M_AXI_WVALID, 0);
                end
            end
        end

        check("rsp_latency", lat, exp_lat);
        check("slave_resp_taken", resp_done, 1);
        if (wr) begin
            check("aw_handshakes", aw_hs, 1);
            check("w_handshakes", w_hs, 1);
            check("awvalid_cycles", aw_seen, aw_dly + 1);
            check("wvalid_cycles", w_seen, w_dly + 1);
        end else begin
            check("ar_handshakes", ar_hs, 1);
            check("arvalid_cycles", ar_seen, ar_dly + 1);
        end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge CLK);
            check("rsp_valid", rsp_valid, 1);
            check("rsp_rdata", rsp_rdata, exp_rdata);
            check("rsp_resp", rsp_resp, resp);
            check("rsp_timeout", rsp_timeout, 0);
            check("rsp_hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", rsp_valid, 0);
        check("cmd_ready_after_hs", cmd_ready, 1);
    endtask

    initial begin
        RSTn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        M_AXI_BRESP = '0;
        M_AXI_RDATA = '0;
        M_AXI_RRESP = '0;
        slave_idle();

        @(negedge CLK);
        check("rst_awvalid", M_AXI_AWVALID, 0);
        check("rst_wvalid", M_AXI_WVALID, 0);
        check("rst_arvalid", M_AXI_ARVALID, 0);
        check("rst_rready", M_AXI_RREADY, 0);
        check("rst_bready", M_AXI_BREADY, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_resp", rsp_resp, 0);
        check("rst_awaddr", M_AXI_AWADDR, 0);
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Write, AWREADY then WREADY one cycle later, OKAY.
        run_txn(1'b1, 32'h0000_0101, 32'h1, 4'hF, 0, 1, 0, 0, 32'h0, 2'b00, 0);
        // Read, ARREADY after 3 cycles.
        run_txn(1'b0, 32'h0000_0205, 32'h0, 4'h0, 0, 0, 3, 0, 32'hDEAD_BEEF, 2'b00, 0);
        // Write, WREADY before AWREADY, SLVERR.
        run_txn(1'b1, 32'h0000_0310, 32'hCAFE_0001, 4'h3, 2, 0, 0, 1, 32'h0, 2'b10, 0);
        // Read held at rsp for 5 cycles, then immediately another command.
        run_txn(1'b0, 32'h0000_0420, 32'h0, 4'h0, 0, 0, 0, 2, 32'h1234_5678, 2'b00, 5);
        // Zero-wait read and write.
        run_txn(1'b0, 32'h0000_0500, 32'h0, 4'h0, 0, 0, 0, 0, 32'hA5A5_5A5A, 2'b01, 0);
        run_txn(1'b1, 32'h0000_0504, 32'h5A5A_A5A5, 4'h9, 0, 0, 0, 0, 32'h0, 2'b11, 0);

        for (int i = 0; i < 24; i++) begin
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    $urandom, 2'($urandom), int'($urandom_range(0, 2)));
        end

`ifdef AXIL_MASTER_TIMEOUT_EN
        begin
            int seen = -1;
            @(negedge CLK);
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = 32'h0000_0600;
            for (int c = 1; c <= 40 && seen < 0; c++) begin
                @(negedge CLK);
                cmd_valid = 1'b0;
                if (rsp_valid) seen = c;
                else check("to_arvalid_held", M_AXI_ARVALID, 1);
            end
            check("to_latency", seen, TO);
            check("to_flag", rsp_timeout, 1);
            check("to_resp", rsp_resp, 2'b10);
            check("to_rdata", rsp_rdata, 0);
            rsp_ready = 1'b1;
            @(negedge CLK);
            rsp_ready = 1'b0;
            check("drain_cmd_ready", cmd_ready, 0);
            check("drain_arvalid", M_AXI_ARVALID, 1);
            check("drain_rready", M_AXI_RREADY, 1);
            M_AXI_ARREADY = 1'b1;
            @(negedge CLK);
            M_AXI_ARREADY = 1'b0;
            check("drain_arvalid_done", M_AXI_ARVALID, 0);
            check("drain_cmd_ready_wait_r", cmd_ready, 0);
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = 32'hBAD0_BAD0;
            @(negedge CLK);
            M_AXI_RVALID = 1'b0;
            check("drain_exit_cmd_ready", cmd_ready, 1);
            check("drain_exit_rsp_valid", rsp_valid, 0);
        end
`endif

        // Reset pulsed while waiting for read data.
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0700;
        @(negedge CLK);
        cmd_valid = 1'b0;
        check("mr_arvalid", M_AXI_ARVALID, 1);
        M_AXI_ARREADY = 1'b1;
        @(negedge CLK);
        M_AXI_ARREADY = 1'b0;
        check("mr_rready_before", M_AXI_RREADY, 1);
        #2 RSTn = 1'b0;
        #1;
        check("mr_arvalid_rst", M_AXI_ARVALID, 0);
        check("mr_awvalid_rst", M_AXI_AWVALID, 0);
        check("mr_wvalid_rst", M_AXI_WVALID, 0);
        check("mr_rready_rst", M_AXI_RREADY, 0);
        check("mr_bready_rst", M_AXI_BREADY, 0);
        check("mr_rsp_valid_rst", rsp_valid, 0);
        @(negedge CLK);
        RSTn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("mr_no_rsp", rsp_valid, 0);
            check("mr_cmd_ready", cmd_ready, 1);
        end
        run_txn(1'b0, 32'h0000_0800, 32'h0, 4'h0, 0, 0, 1, 0, 32'h0BAD_F00D, 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
